// File: rtl/huffman_decoder.sv
// Serial Huffman decoder: shifts code bits in MSB-first and scans the shared code table
// one entry per cycle until a (len, code) match yields the 7-bit ASCII symbol.

module huffman_table (
  input  logic [6:0] idx,
  output logic [9:0] code,
  output logic [3:0] len
);
  // Canonical code: 16x5b (0x60-0x6F), 32x7b (0x20-0x3F), 64x9b, 16x10b (0x10-0x1F).
  // Kraft sum is below one, so codes 912..1023 at 10 bits stay unused.
  always_comb begin
    code = '0;
    len  = '0;
    if (idx[6:4] == 3'b110) begin
      len  = 4'd5;
      code = {6'd0, idx[3:0]};
    end else if (idx[6:5] == 2'b01) begin
      len  = 4'd7;
      code = 10'd64 + {5'd0, idx[4:0]};
    end else if (idx[6:5] == 2'b10) begin
      len  = 4'd9;
      code = 10'd384 + {5'd0, idx[4:0]};
    end else if (idx[6:4] == 3'b111) begin
      len  = 4'd9;
      code = 10'd416 + {6'd0, idx[3:0]};
    end else if (idx[6:4] == 3'b000) begin
      len  = 4'd9;
      code = 10'd432 + {6'd0, idx[3:0]};
    end else begin
      len  = 4'd10;
      code = 10'd896 + {6'd0, idx[3:0]};
    end
  end
endmodule

module huffman_decoder #(
  parameter int MAX_LEN = 10,
  parameter int NSYM    = 128
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  output logic [6:0] ascii_out,
  output logic       valid_out,
  input  logic       out_ready,
  output logic       error,
  output logic       busy
);
  localparam logic [6:0] LAST_IDX = 7'(NSYM - 1);
  localparam logic [3:0] MAX_CNT  = 4'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD, ERR} state_t;

  state_t             state;
  logic [MAX_LEN-1:0] acc;
  logic [3:0]         cnt;
  logic [6:0]         idx;
  logic [9:0]         tbl_code;
  logic [3:0]         tbl_len;
  logic               hit;

  huffman_table u_table (
    .idx  (idx),
    .code (tbl_code),
    .len  (tbl_len)
  );

  // len==0 entries are unused slots and must never match an empty accumulator.
  assign hit       = (tbl_len != 4'd0) && (tbl_len == cnt) && (tbl_code == acc);
  assign bit_ready = (state == IDLE);
  assign busy      = (cnt != 4'd0) || (state == SCAN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      idx       <= '0;
      ascii_out <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      idx       <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bit_valid) begin
            acc   <= {acc[MAX_LEN-2:0], bit_in};
            cnt   <= cnt + 4'd1;
            idx   <= '0;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (hit) begin
            ascii_out <= idx;
            valid_out <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
            state     <= HOLD;
          end else if (idx != LAST_IDX) begin
            idx <= idx + 7'd1;
          end else if (cnt < MAX_CNT) begin
            state <= IDLE;
          end else begin
            // Clearing on entry lets busy drop while the error pulse is visible.
            acc   <= '0;
            cnt   <= '0;
            idx   <= '0;
            error <= 1'b1;
            state <= ERR;
          end
        end
        HOLD: begin
          if (out_ready) begin
            valid_out <= 1'b0;
            state     <= IDLE;
          end
        end
        ERR: begin
          error <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_huffman_decoder.sv
// Bench for huffman_decoder: table-driven code vectors, hand-built corner sequences and a
// random round-trip, all checked through an expected-symbol queue.
module tb_huffman_decoder;
  logic       clk, reset, flush, bit_in, bit_valid, bit_ready;
  logic [6:0] ascii_out;
  logic       valid_out, out_ready, error, busy;

  int chk = 0;
  int errs = 0;
  int err_seen = 0;
  int rx_cnt = 0;
  logic [6:0] exp_q[$];

  huffman_decoder #(.MAX_LEN(10), .NSYM(128)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .ascii_out(ascii_out), .valid_out(valid_out),
    .out_ready(out_ready), .error(error), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    chk++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference encoding of the code table, written from its range description.
  function automatic void enc(input logic [6:0] s, output logic [9:0] c, output int l);
    int v;
    v = int'(s);
    if (v >= 'h60 && v <= 'h6F)      begin l = 5;  c = 10'(v - 'h60); end
    else if (v >= 'h20 && v <= 'h3F) begin l = 7;  c = 10'(64 + v - 'h20); end
    else if (v >= 'h40 && v <= 'h5F) begin l = 9;  c = 10'(384 + v - 'h40); end
    else if (v >= 'h70)              begin l = 9;  c = 10'(416 + v - 'h70); end
    else if (v <= 'h0F)              begin l = 9;  c = 10'(432 + v); end
    else                             begin l = 10; c = 10'(896 + v - 'h10); end
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (error) err_seen++;
      if (valid_out && out_ready) begin
        if (exp_q.size() == 0) begin
          chk++; errs++;
          $display("FAIL unexpected_symbol: got 0x%0h with no symbol outstanding", ascii_out);
        end else begin
          check("symbol", int'(ascii_out), int'(exp_q.pop_front()));
          rx_cnt++;
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    int t;
    t = 0;
    bit_in = b;
    bit_valid = 1'b1;
    @(negedge clk);
    while (!bit_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (!bit_ready) begin
      chk++; errs++;
      $display("FAIL bit_ready_timeout: bit_ready=0 after %0d cycles, required 1", t);
    end
    @(posedge clk); #1;
    bit_valid = 1'b0;
  endtask

  task automatic send_code(input logic [9:0] c, input int l);
    for (int i = l - 1; i >= 0; i--) send_bit(c[i]);
  endtask

  task automatic send_sym(input logic [6:0] s);
    logic [9:0] c;
    int l;
    enc(s, c, l);
    exp_q.push_back(s);
    send_code(c, l);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(exp_q.size() == 0 && !busy && !valid_out && bit_ready) && t < 4000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 4000) begin
      chk++; errs++;
      $display("FAIL idle_timeout: queue=%0d busy=%0b valid_out=%0b, required drained", exp_q.size(), busy, valid_out);
    end
  endtask

  typedef struct {
    logic [9:0] code;
    int         len;
    logic [6:0] sym;
  } vec_t;
  vec_t vecs[10];

  logic        rand_done;
  logic [9:0]  bad_code;

  initial begin
    int lat, e0, r0, l;
    logic [9:0] c;
    logic used;

    vecs[0] = '{10'b00101,      5,  7'h65};
    vecs[1] = '{10'b1000000,    7,  7'h20};
    vecs[2] = '{10'b00001,      5,  7'h61};
    vecs[3] = '{10'b00000,      5,  7'h60};
    vecs[4] = '{10'b110101111,  9,  7'h7F};
    vecs[5] = '{10'b1110000000, 10, 7'h10};
    vecs[6] = '{10'b1110001111, 10, 7'h1F};
    vecs[7] = '{10'b110110000,  9,  7'h00};
    vecs[8] = '{10'b110000001,  9,  7'h41};
    vecs[9] = '{10'b1011111,    7,  7'h3F};

    reset = 1'b1; flush = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; out_ready = 1'b1;
    rand_done = 1'b0;
    @(negedge clk);
    check("rst_valid_out", int'(valid_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_bit_ready", int'(bit_ready), 1);
    check("rst_ascii_out", int'(ascii_out), 0);
    check("rst_error", int'(error), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // 'e' with consumer stalled: latency and hold behaviour
    out_ready = 1'b0;
    send_sym(7'h65);
    lat = 0;
    while (!valid_out && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    check("e_latency", lat, 102);
    check("e_ascii", int'(ascii_out), 'h65);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("e_hold_valid", int'(valid_out), 1);
      check("e_hold_ready", int'(bit_ready), 0);
    end
    out_ready = 1'b1;
    wait_idle();
    check("e_rx", rx_cnt, 1);

    // "ab" back to back, first symbol stalled for 5 cycles
    out_ready = 1'b0;
    fork
      begin
        send_sym(7'h61);
        send_sym(7'h62);
      end
      begin
        lat = 0;
        while (!valid_out && lat < 2000) begin
          @(posedge clk); #1;
          lat++;
        end
        for (int i = 0; i < 5; i++) begin
          check("ab_hold_ready", int'(bit_ready), 0);
          check("ab_hold_ascii", int'(ascii_out), 'h61);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_idle();
    check("ab_rx", rx_cnt, 3);

    // flush after 3 bits of 'a', then a space
    e0 = err_seen;
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", int'(busy), 0);
    check("flush_ready", int'(bit_ready), 1);
    send_sym(7'h20);
    wait_idle();
    check("flush_ascii", int'(ascii_out), 'h20);
    check("flush_err", err_seen, e0);

    // table vectors
    for (int v = 0; v < 10; v++) begin
      e0 = err_seen;
      exp_q.push_back(vecs[v].sym);
      send_code(vecs[v].code, vecs[v].len);
      wait_idle();
      check("vec_ascii", int'(ascii_out), int'(vecs[v].sym));
      check("vec_err", err_seen, e0);
    end

    // invalid 10-bit code found by scanning the reference table
    bad_code = '0;
    for (int v = 1023; v >= 0; v--) begin
      used = 1'b0;
      for (int s = 0; s < 128; s++) begin
        enc(7'(s), c, l);
        if ((10'(v) >> (10 - l)) == c) used = 1'b1;
      end
      if (!used) begin
        bad_code = 10'(v);
        break;
      end
    end
    e0 = err_seen;
    send_code(bad_code, 10);
    lat = 0;
    while (!error && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bad_latency", lat, 128);
    check("bad_busy_during", int'(busy), 0);
    @(posedge clk); #1;
    check("bad_error_width", int'(error), 0);
    check("bad_busy_after", int'(busy), 0);
    check("bad_ascii_kept", int'(ascii_out), 'h3F);
    wait_idle();
    check("bad_err_count", err_seen, e0 + 1);

    // reset in the middle of a scan
    send_bit(1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("mid_scan_busy", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", int'(valid_out), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_ready", int'(bit_ready), 1);
    check("mid_rst_ascii", int'(ascii_out), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // random round-trip with consumer stalls
    e0 = err_seen;
    r0 = rx_cnt;
    fork
      begin
        for (int n = 0; n < 30; n++) begin
          if ($urandom_range(1) == 1) send_sym(7'(7'h60 + $urandom_range(15)));
          else send_sym(7'($urandom_range(127)));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_idle();
    check("rand_rx", rx_cnt - r0, 30);
    check("rand_err", err_seen, e0);

    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end
endmodule
